// File: rtl/shift_seq_pkg.sv
// Shared types for the multi-cycle ALU shift sequencer.
// Optional early-exit build is selected with SHIFT_SKIP_EN.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_seq_ctrl_stage.sv
// One binary shift stage: shifts/rotates acc by 2^k when en is set.
// Time-multiplexed across all stages by the controller.
module shift_stage
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   acc,
  input  shift_op_e          op,
  input  logic               fill,
  input  logic [SHAMT_W-1:0] k,
  input  logic               en,
  output logic [WIDTH-1:0]   res
);

  logic [SHAMT_W:0] sh;
  logic [SHAMT_W:0] rsh;
  logic [WIDTH-1:0] ones;

  always_comb begin
    sh   = (SHAMT_W+1)'(1) << k;
    rsh  = (SHAMT_W+1)'(WIDTH) - sh;
    ones = '1;
    res  = acc;
    if (en) begin
      case (op)
        OP_SRL: res = acc >> sh;
        OP_SLL: res = acc << sh;
        // sign fill comes from the operand MSB captured at accept
        OP_SRA: res = (acc >> sh)
                    | (fill ? ~(ones >> sh) : '0);
        OP_ROR: res = (acc >> sh) | (acc << rsh);
        default: res = acc;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: one binary stage per clock.
// SHIFT_SKIP_EN enables early exit once remaining amount bits are zero.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  seq_state_e         state;
  seq_state_e         state_nxt;
  shift_op_e          op_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   stage_out;
  logic [SHAMT_W-1:0] amt_q;
  logic [SHAMT_W-1:0] cnt;
  logic               fill;
  logic               zero_q;
  logic               last;
  logic               direct;
  logic               unused_amt;

  // only the low SHAMT_W amount bits matter
  assign unused_amt = ^in_amt[WIDTH-1:SHAMT_W];

`ifdef SHIFT_SKIP_EN
  assign last   = ((amt_q >> cnt) >> 1) == '0;
  assign direct = in_amt[SHAMT_W-1:0] == '0;
`else
  assign last   = cnt == SHAMT_W'(SHAMT_W-1);
  assign direct = 1'b0;
`endif

  shift_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .acc  (acc),
    .op   (op_q),
    .fill (fill),
    .k    (cnt),
    .en   (amt_q[cnt]),
    .res  (stage_out)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = direct ? DONE : SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_SRL;
      acc    <= '0;
      res    <= '0;
      amt_q  <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= shift_op_e'(in_op);
            acc   <= in_data;
            amt_q <= in_amt[SHAMT_W-1:0];
            fill  <= in_data[WIDTH-1];
            cnt   <= '0;
            if (direct) begin
              res    <= in_data;
              zero_q <= in_data == '0;
            end
          end
        end
        SHIFT: begin
          acc <= stage_out;
          cnt <= cnt + 1'b1;
          if (last) begin
            res    <= stage_out;
            zero_q <= stage_out == '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data  = res;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: vector table,
// scoreboard queue, reset/hold corner cases and random ops.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [31:0] in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] amt;
    logic [31:0] exp_data;
    logic        exp_zero;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  shift_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(
    input logic [1:0] op, input logic [31:0] d,
    input logic [31:0] amt);
    int a;
    logic [63:0] dd;
    a  = int'(amt[4:0]);
    dd = {d, d};
    case (op)
      2'b00:   return d >> a;
      2'b01:   return d << a;
      2'b10:   return 32'($signed(d) >>> a);
      default: return dd[31:0] >> 0 == 0 ? 32'h0
                      : 32'(dd >> a);
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] amt);
`ifdef SHIFT_SKIP_EN
    int h;
    h = -1;
    for (int i = 0; i < 5; i++)
      if (amt[i]) h = i;
    return (h < 0) ? 1 : h + 2;
`else
    return 6;
`endif
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op,
                       input logic [31:0] data,
                       input logic [31:0] amt,
                       input logic [31:0] exp_data,
                       input logic exp_zero,
                       input int hold,
                       input bit rnd_ready);
    exp_t e;
    int n;
    e.data = exp_data;
    e.zero = exp_zero;
    e.lat  = exp_lat(amt);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_amt   = amt;
    tick();
    sbq.push_back(e);
    in_valid = $urandom_range(0, 1);
    in_op    = 2'($urandom);
    in_data  = $urandom;
    in_amt   = $urandom;
    if (rnd_ready) out_ready = $urandom_range(0, 1);
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(n), 64'(e.lat));
    e = sbq.pop_front();
    chk("out_data", 64'(out_data), 64'(e.data));
    chk("out_zero", 64'(out_zero), 64'(e.zero));
    chk("excl_ready", 64'(in_ready), 0);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_data", 64'(out_data), 64'(e.data));
      chk("hold_zero", 64'(out_zero), 64'(e.zero));
      chk("hold_ready", 64'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 0);
    chk("drain_ready", 64'(in_ready), 1);
  endtask

  vec_t vt[8];

  initial begin
    logic [1:0]  rop;
    logic [31:0] rd;
    logic [31:0] ra;
    logic [31:0] re;

    vt[0] = '{2'b00, 32'hF000_0000, 32'd4,  32'h0F00_0000, 1'b0, 10};
    vt[1] = '{2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 0};
    vt[2] = '{2'b01, 32'h0000_0001, 32'h25, 32'h0000_0020, 1'b0, 0};
    vt[3] = '{2'b11, 32'h0000_0001, 32'd1,  32'h8000_0000, 1'b0, 0};
    vt[4] = '{2'b00, 32'h0000_0008, 32'd4,  32'h0000_0000, 1'b1, 2};
    vt[5] = '{2'b01, 32'h0000_1234, 32'd0,  32'h0000_1234, 1'b0, 0};
    vt[6] = '{2'b10, 32'h7FFF_0000, 32'd8,  32'h007F_FF00, 1'b0, 0};
    vt[7] = '{2'b11, 32'h1234_5678, 32'd16, 32'h5678_1234, 1'b0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", 64'(in_ready), 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_zero", 64'(out_zero), 0);

    for (int i = 0; i < 8; i++)
      do_op(vt[i].op, vt[i].data, vt[i].amt,
            vt[i].exp_data, vt[i].exp_zero,
            vt[i].hold, 1'b0);

    // reset in the middle of a shift aborts it
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 32'hFFFF_FFFF;
    in_amt   = 32'd31;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 64'(in_ready), 1);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_data", 64'(out_data), 0);
    chk("midrst_zero", 64'(out_zero), 0);
    do_op(2'b00, 32'h8000_0000, 32'd31,
          32'h0000_0001, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      rop = 2'($urandom);
      rd  = $urandom;
      ra  = (i % 7 == 0) ? 32'($urandom_range(0, 1)) << 5
                         : $urandom;
      re  = ref_shift(rop, rd, ra);
      do_op(rop, rd, ra, re, re == 0,
            (i % 50 == 0) ? 3 : 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
